// File: rtl/l1_relu_drain.sv
// l1_relu_drain: counts accumulation beats, snapshots the layer-1 sums each frame,
// then streams ReLU/shift/saturated activations to layer 2 one node per handshake.
module l1_relu_drain #(
  parameter int RELU_NODES = 10,
  parameter int LAYER_1_BIT_WIDTH = 16,
  parameter int OUT_WIDTH = 8,
  parameter int N_INPUTS = 784,
  parameter int FRAC_SHIFT = 4,
  localparam int IW = RELU_NODES > 1 ? $clog2(RELU_NODES) : 1
) (
  input  logic                                      clk,
  input  logic                                      clr,
  input  logic                                      accValid,
  input  logic [RELU_NODES*LAYER_1_BIT_WIDTH-1:0]   sumIn,
  output logic                                      accClr,
  output logic                                      busy,
  output logic                                      actValid,
  input  logic                                      actReady,
  output logic [OUT_WIDTH-1:0]                      actOut,
  output logic [IW-1:0]                             actIdx,
  output logic                                      frameDone
);
  localparam int W = LAYER_1_BIT_WIDTH;
  localparam int CW = $clog2(N_INPUTS);
  localparam logic [W-1:0] MAXV = W'((1 << OUT_WIDTH) - 1);

  typedef enum logic [1:0] {ACCUM, CAPTURE, STREAM} state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic fd_q, fd_d;
  logic [W-1:0] buf_q [RELU_NODES];
  logic beat, last_beat, hs, last_node;

  function automatic logic [OUT_WIDTH-1:0] relu(input logic [W-1:0] s);
    logic [W-1:0] t;
    t = s >> FRAC_SHIFT;
    return s[W-1] ? '0 : (t > MAXV) ? '1 : t[OUT_WIDTH-1:0];
  endfunction

  assign beat = state_q == ACCUM && accValid;
  assign last_beat = beat && cnt_q == CW'(N_INPUTS - 1);
  assign hs = state_q == STREAM && actReady;
  assign last_node = idx_q == IW'(RELU_NODES - 1);

  always_ff @(posedge clk or negedge clr)
    if (!clr) state_q <= ACCUM;
    else state_q <= state_d;

  always_comb begin
    state_d = last_beat ? CAPTURE :
              state_q == CAPTURE ? STREAM :
              (hs && last_node) ? ACCUM : state_q;
  end

  always_comb begin
    busy = state_q != ACCUM;
    accClr = state_q == CAPTURE;
    actValid = state_q == STREAM;
    actIdx = actValid ? idx_q : '0;
    actOut = actValid ? relu(buf_q[idx_q]) : '0;
    frameDone = fd_q;
  end

  always_comb begin
    cnt_d = last_beat ? '0 : beat ? cnt_q + 1'b1 : cnt_q;
    idx_d = state_q == CAPTURE ? '0 : !hs ? idx_q : last_node ? '0 : idx_q + 1'b1;
    fd_d = hs && last_node;
  end

  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      cnt_q <= '0;
      idx_q <= '0;
      fd_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      fd_q <= fd_d;
    end

  // Snapshot taken on the edge leaving CAPTURE, when the accumulator's last add is visible
  always_ff @(posedge clk or negedge clr)
    if (!clr) for (int k = 0; k < RELU_NODES; k++) buf_q[k] <= '0;
    else if (state_q == CAPTURE) for (int k = 0; k < RELU_NODES; k++) buf_q[k] <= sumIn[k*W +: W];
endmodule

// File: tb/tb_l1_relu_drain.sv
// tb_l1_relu_drain: randomized frames with a queue scoreboard and a cycle-level protocol monitor.
module tb_l1_relu_drain;
  localparam int N = 4, NODES = 4, W = 16, OW = 8, FS = 4, IW = 2;

  logic clk = 1'b0, clr = 1'b1, accValid = 1'b0, actReady = 1'b0;
  logic [NODES*W-1:0] sumIn = '0;
  logic accClr, busy, actValid, frameDone;
  logic [OW-1:0] actOut;
  logic [IW-1:0] actIdx;

  typedef struct {int idx; int val;} exp_t;
  typedef logic [W-1:0] lanes_t [NODES];
  exp_t q[$];
  int checks = 0, errors = 0, rmode = 0;

  always #5 clk = ~clk;

  l1_relu_drain #(.RELU_NODES(NODES), .LAYER_1_BIT_WIDTH(W), .OUT_WIDTH(OW),
                  .N_INPUTS(N), .FRAC_SHIFT(FS)) dut (
    .clk(clk), .clr(clr), .accValid(accValid), .sumIn(sumIn), .accClr(accClr),
    .busy(busy), .actValid(actValid), .actReady(actReady), .actOut(actOut),
    .actIdx(actIdx), .frameDone(frameDone));

  function automatic int f(input logic [W-1:0] s);
    int v;
    v = int'($signed(s));
    if (v < 0) return 0;
    v = v / (1 << FS);
    return v > (1 << OW) - 1 ? (1 << OW) - 1 : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int outs_all();
    return int'({accClr, busy, actValid, frameDone, actOut, actIdx});
  endfunction

  initial begin
    int p = 0;
    forever begin
      @(posedge clk);
      #1;
      actReady = rmode == 0 ? 1'b1 : rmode == 1 ? (p % 3 == 0) : 1'($urandom_range(0, 1));
      p++;
    end
  end

  // Protocol monitor: spec-level cycle expectations plus scoreboard pops on each accepted activation
  int mcnt = 0;
  bit cap_p = 0, strm = 0, fd_p = 0, stall = 0;
  logic [OW-1:0] p_out;
  logic [IW-1:0] p_idx;
  always @(negedge clk) begin
    bit hs, last, bsy;
    exp_t e;
    if (!clr) begin
      chk("reset_outputs", outs_all(), 0);
      mcnt = 0; cap_p = 0; strm = 0; fd_p = 0; stall = 0;
    end else begin
      bsy = cap_p || strm;
      chk("accClr", int'(accClr), int'(cap_p));
      chk("busy", int'(busy), int'(bsy));
      chk("actValid", int'(actValid), int'(strm));
      chk("frameDone", int'(frameDone), int'(fd_p));
      if (stall && actValid) begin
        chk("hold_actOut", int'(actOut), int'(p_out));
        chk("hold_actIdx", int'(actIdx), int'(p_idx));
      end
      hs = actValid && actReady;
      last = 0;
      if (hs) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_activation: got idx %0d val %0d, expected none", actIdx, actOut);
          last = actIdx == IW'(NODES - 1);
        end else begin
          e = q.pop_front();
          chk("actIdx", int'(actIdx), e.idx);
          chk("actOut", int'(actOut), e.val);
          last = e.idx == NODES - 1;
        end
      end
      stall = actValid && !actReady;
      p_out = actOut;
      p_idx = actIdx;
      fd_p = hs && last;
      strm = cap_p ? 1'b1 : (hs && last) ? 1'b0 : strm;
      cap_p = !bsy && accValid && mcnt == N - 1;
      if (!bsy && accValid) mcnt = mcnt == N - 1 ? 0 : mcnt + 1;
    end
  end

  task automatic push_frame(input lanes_t l);
    for (int k = 0; k < NODES; k++) begin
      q.push_back('{k, f(l[k])});
      sumIn[k*W +: W] = l[k];
    end
  endtask

  task automatic beats(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1 accValid = 1'b0; end
      @(posedge clk);
      #1 accValid = 1'b1;
    end
    @(posedge clk);
    #1 accValid = 1'b0;
  endtask

  task automatic wait_fd();
    int n = 0;
    while (n < 200 && frameDone !== 1'b1) begin @(negedge clk); n++; end
    checks++;
    if (frameDone !== 1'b1) begin errors++; $display("FAIL frameDone_timeout: got %b expected 1", frameDone); end
  endtask

  task automatic wait_accclr();
    int n = 0;
    do begin @(negedge clk); n++; end while (accClr !== 1'b1 && n < 200);
    checks++;
    if (accClr !== 1'b1) begin errors++; $display("FAIL accClr_timeout: got %b expected 1", accClr); end
  endtask

  task automatic async_reset();
    clr = 1'b0;
    accValid = 1'b0;
    q.delete();
    #1 chk("async_reset_outputs", outs_all(), 0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
  endtask

  initial begin
    lanes_t r;
    int n;
    #1 clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    // reset mid-accumulation: the two partial beats must be forgotten
    @(posedge clk); #1 accValid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #3 async_reset();
    rmode = 0;
    push_frame('{16'h0050, 16'hFFF0, 16'h2000, 16'h0000});
    beats(4, 0);
    wait_fd();
    rmode = 1;
    push_frame('{16'h0050, 16'hFFF0, 16'h2000, 16'h0000});
    beats(4, 0);
    wait_fd();
    // accValid held high across busy: only non-busy beats may count
    rmode = 0;
    push_frame('{16'h0100, 16'h0020, 16'h7FFF, 16'hFFFF});
    @(posedge clk); #1 accValid = 1'b1;
    wait_accclr();
    @(posedge clk); #1 push_frame('{16'h0330, 16'h0011, 16'h8001, 16'h00F0});
    wait_accclr();
    @(posedge clk); #1 accValid = 1'b0;
    wait_fd();
    rmode = 2;
    push_frame('{16'h0FF0, 16'h0FFF, 16'h1000, 16'h000F});
    beats(4, 1);
    wait_fd();
    push_frame('{16'h8000, 16'h7FFF, 16'h0010, 16'h001F});
    beats(4, 1);
    wait_fd();
    repeat (6) begin
      for (int k = 0; k < NODES; k++) r[k] = $urandom_range(0, 3) == 0 ? W'($urandom_range(3900, 4200)) : W'($urandom);
      push_frame(r);
      beats(4, 1);
      wait_fd();
    end
    // reset while streaming node 2, then a clean frame from node 0
    rmode = 0;
    push_frame('{16'h0040, 16'h0080, 16'h00C0, 16'h0100});
    beats(4, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(actValid && actIdx == 2'd2) && n < 200);
    chk("reached_idx2", int'(actIdx), 2);
    #3 async_reset();
    push_frame('{16'h0123, 16'hF000, 16'h0F00, 16'h0008});
    beats(4, 0);
    wait_fd();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
